// File: rtl/lsu.sv
// Load/store stage: owns the data-RAM port, one transaction per instruction.
// Optional LSU_MISALIGN_CHK_EN traps misaligned H/W without touching RAM.
module lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sys_valid,
  output logic              o_sys_ready,
  input  logic              i_idu_ctr_ram_rd_en,
  input  logic              i_idu_ctr_ram_wr_en,
  input  logic [2:0]        i_idu_ctr_ram_byt,
  input  logic [ADDR_W-1:0] i_exu_res,
  input  logic [DATA_W-1:0] i_gpr_rd_data2,
  output logic              o_ram_req_valid,
  input  logic              i_ram_req_ready,
  output logic              o_ram_req_wr,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wr_data,
  output logic [3:0]        o_ram_wr_mask,
  input  logic              i_ram_resp_valid,
  input  logic [DATA_W-1:0] i_ram_rd_data,
  output logic              o_sys_valid,
  input  logic              i_sys_ready,
  output logic [DATA_W-1:0] o_lsu_res
`ifdef LSU_MISALIGN_CHK_EN
  ,
  output logic              o_lsu_misalign
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  logic [2:0]  byt_q;
  logic [1:0]  off_q;
  logic        ld_q;

  logic [1:0]  off_d;
  logic        memop;
  logic        go_mem;
  logic [3:0]  mask_d;
  logic [DATA_W-1:0] ld_sh;
  logic [DATA_W-1:0] ld_ext;

  assign off_d = i_exu_res[1:0];
  assign memop = i_idu_ctr_ram_rd_en | i_idu_ctr_ram_wr_en;

  // Lanes shifted past byte 3 simply fall off the 4-bit mask.
  always_comb begin
    mask_d = 4'b0000;
    unique case (i_idu_ctr_ram_byt)
      3'b000, 3'b100: mask_d = 4'b0001 << off_d;
      3'b001, 3'b101: mask_d = 4'b0011 << off_d;
      default:        mask_d = 4'b1111 << off_d;
    endcase
  end

`ifdef LSU_MISALIGN_CHK_EN
  logic mis_d;

  always_comb begin
    mis_d = 1'b0;
    unique case (i_idu_ctr_ram_byt)
      3'b000, 3'b100: mis_d = 1'b0;
      3'b001, 3'b101: mis_d = off_d[0];
      default:        mis_d = |off_d;
    endcase
  end

  assign go_mem = memop & ~mis_d;
`else
  assign go_mem = memop;
`endif

  assign ld_sh = i_ram_rd_data >> {off_q, 3'b000};

  always_comb begin
    ld_ext = ld_sh;
    unique case (byt_q)
      3'b000:  ld_ext = {{(DATA_W-8){ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_ext = {{(DATA_W-16){ld_sh[15]}}, ld_sh[15:0]};
      3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, ld_sh[7:0]};
      3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, ld_sh[15:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= S_IDLE;
      byt_q           <= 3'b000;
      off_q           <= 2'b00;
      ld_q            <= 1'b0;
      o_sys_ready     <= 1'b1;
      o_sys_valid     <= 1'b0;
      o_ram_req_valid <= 1'b0;
      o_ram_req_wr    <= 1'b0;
      o_ram_addr      <= '0;
      o_ram_wr_data   <= '0;
      o_ram_wr_mask   <= 4'b0000;
      o_lsu_res       <= '0;
`ifdef LSU_MISALIGN_CHK_EN
      o_lsu_misalign  <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_sys_valid) begin
            byt_q       <= i_idu_ctr_ram_byt;
            off_q       <= off_d;
            ld_q        <= i_idu_ctr_ram_rd_en & ~i_idu_ctr_ram_wr_en;
            o_sys_ready <= 1'b0;
            if (go_mem) begin
              state           <= S_REQ;
              o_ram_req_valid <= 1'b1;
              o_ram_req_wr    <= i_idu_ctr_ram_wr_en;
              o_ram_addr      <= {i_exu_res[ADDR_W-1:2], 2'b00};
              o_ram_wr_data   <= i_gpr_rd_data2 << {off_d, 3'b000};
              o_ram_wr_mask   <= mask_d;
            end else begin
              state       <= S_DONE;
              o_sys_valid <= 1'b1;
              o_lsu_res   <= '0;
`ifdef LSU_MISALIGN_CHK_EN
              o_lsu_misalign <= memop;
`endif
            end
          end
        end
        S_REQ: begin
          if (i_ram_req_ready) begin
            state           <= S_WAIT;
            o_ram_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (i_ram_resp_valid) begin
            state       <= S_DONE;
            o_sys_valid <= 1'b1;
            o_lsu_res   <= ld_q ? ld_ext : '0;
          end
        end
        S_DONE: begin
          if (i_sys_ready) begin
            state       <= S_IDLE;
            o_sys_valid <= 1'b0;
            o_sys_ready <= 1'b1;
`ifdef LSU_MISALIGN_CHK_EN
            o_lsu_misalign <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases then random ops against a byte-level model.
// Define LSU_MISALIGN_CHK_EN to also exercise the misalign trap.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        sys_valid_i;
  logic        sys_ready_o;
  logic        rd_en;
  logic        wr_en;
  logic [2:0]  byt;
  logic [31:0] exu_res;
  logic [31:0] rs2;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] ram_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        resp_valid;
  logic [31:0] rd_data;
  logic        sys_valid_o;
  logic        sys_ready_i;
  logic [31:0] lsu_res;
`ifdef LSU_MISALIGN_CHK_EN
  logic        lsu_misalign;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_res;
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  lsu dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_sys_valid         (sys_valid_i),
    .o_sys_ready         (sys_ready_o),
    .i_idu_ctr_ram_rd_en (rd_en),
    .i_idu_ctr_ram_wr_en (wr_en),
    .i_idu_ctr_ram_byt   (byt),
    .i_exu_res           (exu_res),
    .i_gpr_rd_data2      (rs2),
    .o_ram_req_valid     (req_valid),
    .i_ram_req_ready     (req_ready),
    .o_ram_req_wr        (req_wr),
    .o_ram_addr          (ram_addr),
    .o_ram_wr_data       (wr_data),
    .o_ram_wr_mask       (wr_mask),
    .i_ram_resp_valid    (resp_valid),
    .i_ram_rd_data       (rd_data),
    .o_sys_valid         (sys_valid_o),
    .i_sys_ready         (sys_ready_i),
    .o_lsu_res           (lsu_res)
`ifdef LSU_MISALIGN_CHK_EN
    ,
    .o_lsu_misalign      (lsu_misalign)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic o_rd, input logic o_wr,
                       input logic [2:0] o_byt, input logic [31:0] addr,
                       input logic [31:0] data, input int rw, input int ow);
    int          off;
    int          size;
    bit          sgn;
    bit          memop;
    bit          st;
    bit          mis;
    logic [31:0] wa;
    logic [3:0]  e_mask;
    logic [31:0] e_data;
    logic [31:0] word;
    logic [31:0] e_res;
    logic [31:0] ones;
    off   = int'(addr[1:0]);
    size  = (o_byt == 3'b000 || o_byt == 3'b100) ? 1 :
            (o_byt == 3'b001 || o_byt == 3'b101) ? 2 : 4;
    sgn   = (o_byt == 3'b000 || o_byt == 3'b001);
    memop = o_rd | o_wr;
    st    = o_wr;
    mis   = 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
    mis = memop && ((size == 2 && off[0]) || (size == 4 && off != 0));
`endif
    wa     = {addr[31:2], 2'b00};
    e_mask = 4'b0000;
    for (int i = 0; i < size; i++)
      if (off + i < 4) e_mask[off+i] = 1'b1;
    e_data = data << (8 * off);
    e_res  = 32'h0;

    chk("idle_ready", {31'b0, sys_ready_o}, 32'h1);
    sys_valid_i = 1'b1;
    rd_en = o_rd;
    wr_en = o_wr;
    byt = o_byt;
    exu_res = addr;
    rs2 = data;
    tick();
    sys_valid_i = 1'b0;
    rd_en = 1'($urandom);
    wr_en = 1'($urandom);
    byt = 3'($urandom);
    exu_res = $urandom;
    rs2 = $urandom;

    if (memop && !mis) begin
      for (int k = 0; k <= rw; k++) begin
        chk("req_valid", {31'b0, req_valid}, 32'h1);
        chk("req_wr", {31'b0, req_wr}, {31'b0, st});
        chk("ram_addr", ram_addr, wa);
        chk("wr_mask", {28'b0, wr_mask}, {28'b0, e_mask});
        chk("wr_data", wr_data, e_data);
        chk("req_no_sysvalid", {31'b0, sys_valid_o}, 32'h0);
        chk("req_not_ready", {31'b0, sys_ready_o}, 32'h0);
        req_ready = (k == rw);
        tick();
      end
      req_ready = 1'b0;
      chk("wait_req_low", {31'b0, req_valid}, 32'h0);
      chk("wait_no_sysvalid", {31'b0, sys_valid_o}, 32'h0);
      if (!mem.exists(wa)) mem[wa] = $urandom;
      word = mem[wa];
      if (st) begin
        for (int j = 0; j < 4; j++)
          if (e_mask[j]) word[8*j +: 8] = e_data[8*j +: 8];
        mem[wa] = word;
        rd_data = $urandom;
      end else begin
        rd_data = word;
        for (int i = 0; i < size; i++)
          if (off + i < 4) e_res[8*i +: 8] = word[8*(off+i) +: 8];
        if (sgn && e_res[8*size-1]) begin
          ones  = '1;
          e_res = e_res | (ones << (8 * size));
        end
      end
      resp_valid = 1'b1;
      tick();
      resp_valid = 1'b0;
      rd_data = $urandom;
    end else begin
      chk("nomem_no_req", {31'b0, req_valid}, 32'h0);
    end

    for (int k = 0; k <= ow; k++) begin
      chk("done_valid", {31'b0, sys_valid_o}, 32'h1);
      chk("done_res", lsu_res, e_res);
      chk("done_not_ready", {31'b0, sys_ready_o}, 32'h0);
      chk("done_no_req", {31'b0, req_valid}, 32'h0);
`ifdef LSU_MISALIGN_CHK_EN
      chk("misalign", {31'b0, lsu_misalign}, {31'b0, mis});
`endif
      sys_ready_i = (k == ow);
      tick();
    end
    sys_ready_i = 1'b0;
    chk("back_idle_valid", {31'b0, sys_valid_o}, 32'h0);
    chk("back_idle_ready", {31'b0, sys_ready_o}, 32'h1);
`ifdef LSU_MISALIGN_CHK_EN
    chk("misalign_clr", {31'b0, lsu_misalign}, 32'h0);
`endif
    last_res = e_res;
  endtask

  initial begin
    logic [2:0]  codes [8];
    logic [2:0]  c;
    logic [31:0] a;
    int          kind;
    codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    rst = 1'b1;
    sys_valid_i = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    byt = 3'b000;
    exu_res = 32'h0;
    rs2 = 32'h0;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    rd_data = 32'h0;
    sys_ready_i = 1'b0;
    last_res = 32'h0;
    #12;
    chk("rst_sys_ready", {31'b0, sys_ready_o}, 32'h1);
    chk("rst_sys_valid", {31'b0, sys_valid_o}, 32'h0);
    chk("rst_req_valid", {31'b0, req_valid}, 32'h0);
    chk("rst_res", lsu_res, 32'h0);
    chk("rst_addr", ram_addr, 32'h0);
    chk("rst_wdata", wr_data, 32'h0);
    chk("rst_mask", {28'b0, wr_mask}, 32'h0);
    chk("rst_wr", {31'b0, req_wr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    mem[32'h1004] = 32'hDEADBEEF;
    do_op(1'b1, 1'b0, 3'b010, 32'h1004, 32'h0, 0, 0);
    chk("lw_deadbeef", last_res, 32'hDEADBEEF);
    mem[32'h1000] = 32'h80FF0000;
    do_op(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 0, 0);
    chk("lb_sign", last_res, 32'hFFFFFF80);
    do_op(1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 0, 0);
    chk("lbu_zero", last_res, 32'h00000080);
    do_op(1'b0, 1'b1, 3'b001, 32'h2002, 32'h00001234, 0, 0);
    chk("sh_word", mem[32'h2000][31:16], 32'h1234);
    do_op(1'b0, 1'b0, 3'b010, 32'h5000, 32'h0, 0, 5);
    do_op(1'b1, 1'b0, 3'b010, 32'h1004, 32'h0, 4, 0);

    resp_valid = 1'b1;
    rd_data = 32'h12345678;
    tick();
    resp_valid = 1'b0;
    chk("stray_resp_res", lsu_res, last_res);
    chk("stray_resp_valid", {31'b0, sys_valid_o}, 32'h0);

    sys_valid_i = 1'b1;
    rd_en = 1'b1;
    wr_en = 1'b0;
    byt = 3'b010;
    exu_res = 32'h1004;
    tick();
    sys_valid_i = 1'b0;
    chk("rst_req_pre", {31'b0, req_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_req_drop", {31'b0, req_valid}, 32'h0);
    chk("rst_req_ready", {31'b0, sys_ready_o}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    sys_valid_i = 1'b1;
    tick();
    sys_valid_i = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_wait_valid", {31'b0, sys_valid_o}, 32'h0);
    chk("rst_wait_req", {31'b0, req_valid}, 32'h0);
    chk("rst_wait_ready", {31'b0, sys_ready_o}, 32'h1);
    chk("rst_wait_res", lsu_res, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    chk("rst_wait_stray", {31'b0, sys_valid_o}, 32'h0);

`ifdef LSU_MISALIGN_CHK_EN
    do_op(1'b1, 1'b0, 3'b010, 32'h3002, 32'h0, 0, 0);
    do_op(1'b0, 1'b1, 3'b001, 32'h3001, 32'hABCD, 0, 1);
`endif

    for (int n = 0; n < 80; n++) begin
      c = codes[$urandom_range(0, 7)];
      a = 32'h4000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
`ifndef LSU_MISALIGN_CHK_EN
      if (!(c == 3'b000 || c == 3'b100 || c == 3'b001 || c == 3'b101))
        a[1:0] = 2'b00;
`endif
      kind = $urandom_range(0, 3);
      do_op(kind[0], kind[1], c, a, $urandom,
            $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
